// File: rtl/rv_core_pkg.sv
// Shared types and sizing constants for the RISC-V single-cycle core.
package rv_core_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/onehot_check.sv
// Classifies the gated write-enable vector: single hit (bit 0 ignored), multi-hit,
// raw bit 0, and the binary index of the selected register.
module onehot_check
    import rv_core_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic [NREG-1:0] vec,
    output logic            valid_one,
    output logic            multi,
    output logic            bit0,
    output reg_addr_t       idx
);

    logic seen;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        idx   = '0;
        for (int k = 1; k < NREG; k++) begin
            if (vec[k]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                idx  = reg_addr_t'(k);
            end
        end
    end

    assign valid_one = seen & ~multi;
    assign bit0      = vec[0];

endmodule

// File: rtl/regfile_onehot.sv
// 32 x XLEN register file written by a one-hot enable vector, with two combinational
// read ports, optional same-cycle write forwarding and a sticky malformed-vector flag.
module regfile_onehot
    import rv_core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NREG-1:0] i_wr_en_onehot,
    input  logic [XLEN-1:0] i_wr_data,
    input  reg_addr_t       i_rs1_addr,
    input  reg_addr_t       i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_wr_err,
    input  logic            i_err_clr
);

    localparam bit BYPASS_EN = (BYPASS != 0);

    logic            valid_one;
    logic            multi;
    logic            bit0;
    reg_addr_t       wr_idx;
    logic [XLEN-1:0] regs [1:NREG-1];
    logic            rs1_hit;
    logic            rs2_hit;

    onehot_check #(.NREG(NREG)) u_onehot_check (
        .vec       (i_wr_en_onehot),
        .valid_one (valid_one),
        .multi     (multi),
        .bit0      (bit0),
        .idx       (wr_idx)
    );

    // NOTE: the array is cleared by reset because software expects x1..x31 to read 0 afterwards; state is updated with <= only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 1; k < NREG; k++) regs[k] <= '0;
        end else if (valid_one) begin
            for (int k = 1; k < NREG; k++) begin
                if (wr_idx == reg_addr_t'(k)) regs[k] <= i_wr_data;
            end
        end
    end

    // Setting wins over a clear arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_err <= 1'b0;
        end else if (multi || bit0) begin
            o_wr_err <= 1'b1;
        end else if (i_err_clr) begin
            o_wr_err <= 1'b0;
        end
    end

    // Forwarding only fires for a legal single write; x0 always reads zero.
    assign rs1_hit = BYPASS_EN && valid_one && (wr_idx == i_rs1_addr);
    assign rs2_hit = BYPASS_EN && valid_one && (wr_idx == i_rs2_addr);

    assign o_rs1_data = (i_rs1_addr == '0) ? '0 :
                        rs1_hit            ? i_wr_data : regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == '0) ? '0 :
                        rs2_hit            ? i_wr_data : regs[i_rs2_addr];

endmodule

// File: doc/regfile_onehot.md
# regfile_onehot

32 × 32-bit integer register file for the RISC-V single-cycle core, sitting directly downstream of the write-enable gating stage. It consumes the gated one-hot write-enable vector and the write-back data, and provides two combinational read ports to the decode/execute path. It also provides a registered sticky error flag for malformed (non-one-hot) write vectors.

## Interface

Parameters:

- `XLEN`, 32, register data width.
- `NREG`, 32, number of architectural registers; fixed at 32 in this core.
- `BYPASS`, 1, when 1 a read of the register being written this cycle returns `i_wr_data`.

Ports:

- `i_clk` input 1: core clock; all state updates occur on its rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_wr_en_onehot` input NREG: gated write-enable vector from the write-enable stage; bit k selects register xk.
- `i_wr_data` input XLEN: write-back data.
- `i_rs1_addr` input 5: read port 1 address.
- `i_rs2_addr` input 5: read port 2 address.
- `o_rs1_data` output XLEN: read port 1 data.
- `o_rs2_data` output XLEN: read port 2 data.
- `o_wr_err` output 1: sticky flag; set when the write vector had more than one bit set, or had bit 0 set.
- `i_err_clr` input 1: synchronous clear of `o_wr_err`.

## Operation

- Storage is registers x1..x31, XLEN bits each. x0 has no storage and always reads 0.
- Write rule, evaluated on each rising edge:
  - Let V = `i_wr_en_onehot` with bit 0 masked to 0.
  - If popcount(V) == 1, the selected register loads `i_wr_data`.
  - If popcount(V) == 0, no register changes.
  - If popcount(V) ≥ 2, no register changes, the write is dropped entirely, and `o_wr_err` sets.
- Bit 0 of the vector set, alone or with others, sets `o_wr_err`. It never writes x0. The rest of V is still judged by the popcount rule above.
- Reads are combinational:
  - `o_rsN_data` = 0 if the address is 0.
  - Otherwise, if `BYPASS` = 1, popcount(V) == 1, and V selects the addressed register, it equals `i_wr_data`.
  - Otherwise it is the stored value.
- Error flag:
  - Set has priority over `i_err_clr` in the same cycle.
  - Once set, it holds until cleared by `i_err_clr`.
- Reset (`i_rst_n` low, asynchronous): all x1..x31 clear to 0 and `o_wr_err` clears to 0 immediately.
  - Reads during reset return 0, apart from any `BYPASS` forwarding of `i_wr_data`.
  - A write coinciding with reset is lost.
  - Reset deassertion is synchronised externally.

## Timing

- Write latency: 1 cycle. Data presented in cycle n is visible from the stored array in cycle n+1.
- Read latency: 0 cycles, combinational from the address and array.
  - With `BYPASS` = 1, same-cycle write data is also visible in cycle n.
  - With `BYPASS` = 0, the old value is returned in cycle n.
- `o_wr_err` is registered: it is asserted in the cycle after the offending vector.
- Simultaneous read of the same register on both ports: both return the identical value.
- Reset values: `o_wr_err` = 0; `o_rs1_data` and `o_rs2_data` = 0 while no write enable is active.

## Structure

- Shared package `rv_core_pkg`:
  - `XLEN`, `NREG`, `REG_ADDR_W` = 5.
  - typedef `reg_addr_t` (logic [4:0]).
  - typedef `xlen_t` (logic [XLEN-1:0]).
- One natural sub-module: `onehot_check`.
  - Combinational.
  - Input: the NREG-bit vector.
  - Outputs: `valid_one` (exactly one bit of V set), `multi` (≥2 bits set), `bit0` (raw bit 0 set).
  - Also produces the binary index of the set bit, used by the bypass compare.
- The top level holds:
  - the array (31 entries);
  - the two read muxes with the x0 and bypass terms;
  - the error flop.

## Test plan

- **Reset and x0:** assert `i_rst_n` = 0 mid-run after writing x5 = 0xDEADBEEF → `o_rs1_data` (rs1 = 5) reads 0 immediately and `o_wr_err` = 0. After release, write vector 0x0000_0001 with data 0x1234 → x0 still reads 0 and `o_wr_err` = 1 the next cycle.
- **Basic write/read:** vector 0x0000_0400 with data 0xCAFEF00D → x10 reads 0xCAFEF00D on both ports the next cycle; all other registers remain 0.
- **Bypass:** `BYPASS` = 1; vector 0x8000_0000 with data 0xA5A5A5A5 and rs2 = 31 in the same cycle → `o_rs2_data` = 0xA5A5A5A5 in that cycle. With `BYPASS` = 0 → the old value 0 in that cycle, then 0xA5A5A5A5 in the next cycle.
- **Multi-hot vector:** vector 0x0000_0006 with data 0x55 → x1 and x2 are unchanged and `o_wr_err` = 1 the next cycle. Assert `i_err_clr` together with a new multi-hot vector → flag stays 1. Assert `i_err_clr` alone → flag returns to 0.
- **Back-to-back:** write x3 = 1, x3 = 2, x4 = 3 on consecutive cycles while reading rs1 = 3 and rs2 = 4 → reads with `BYPASS` = 1 follow 1, 2, 2 on rs1 and 0, 0, 3 on rs2.
- **Idle vector:** vector 0 for 100 cycles with random data → no register changes and `o_wr_err` stays 0.
